// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per cycle from
// instruction memory and queues {PC, instruction} pairs in a small in-order
// buffer that decode drains over a valid/ready handshake. A redirect flushes
// everything that was fetched but not yet consumed.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [61:0]                   Inst_Address,
  input  logic [31:0]                   Instruction,
  input  logic                          Redirect_Valid,
  input  logic [63:0]                   Redirect_PC,
  output logic                          Fetch_Valid,
  input  logic                          Fetch_Ready,
  output logic [31:0]                   Fetch_Instruction,
  output logic [63:0]                   Fetch_PC,
  output logic [$clog2(FIFO_DEPTH):0]   Buffer_Count,
  output logic                          Redirect_Misaligned
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);

  logic [63:0]   pc;
  logic [31:0]   buf_inst [FIFO_DEPTH];
  logic [63:0]   buf_pc   [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          misaligned;
  logic          pop;
  logic          push;

  // A full buffer can still fetch when the head leaves in the same cycle.
  assign Inst_Address        = pc[63:2];
  assign Fetch_Valid         = (count != '0);
  assign pop                 = Fetch_Valid && Fetch_Ready;
  assign push                = (count < DEPTH) || pop;
  assign Fetch_Instruction   = buf_inst[head];
  assign Fetch_PC            = buf_pc[head];
  assign Buffer_Count        = count;
  assign Redirect_Misaligned = misaligned;

  // PC, pointers and occupancy; a redirect overrides normal push/pop bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      misaligned <= 1'b0;
    end else if (Redirect_Valid) begin
      pc         <= {Redirect_PC[63:2], 2'b00};
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      misaligned <= |Redirect_PC[1:0];
    end else begin
      misaligned <= 1'b0;
      if (push) begin
        tail <= tail + 1'b1;
        pc   <= pc + 64'd4;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      // pop always implies push, so occupancy only ever grows or holds here.
      if (push && !pop) begin
        count <= count + 1'b1;
      end
    end
  end

  // Buffer storage: write the fetched word and its PC at the tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (!Redirect_Valid && push) begin
      buf_inst[tail] <= Instruction;
      buf_pc[tail]   <= pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a queue-based reference model of the
// fetch stream feeds a scoreboard that a negedge monitor checks against the
// DUT; a second instance covers the PC wrap from the top of the address space.
module tb_instruction_fetch_unit;

  localparam int          D       = 2;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [61:0] Inst_Address;
  logic [31:0] Instruction;
  logic        Redirect_Valid = 1'b0;
  logic [63:0] Redirect_PC = '0;
  logic        Fetch_Valid;
  logic        Fetch_Ready = 1'b1;
  logic [31:0] Fetch_Instruction;
  logic [63:0] Fetch_PC;
  logic [1:0]  Buffer_Count;
  logic        Redirect_Misaligned;

  logic [61:0] w_inst_address;
  logic [31:0] w_instruction;
  logic        w_fetch_valid;
  logic [31:0] w_fetch_instruction;
  logic [63:0] w_fetch_pc;
  logic [1:0]  w_buffer_count;
  logic        w_misaligned;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_pc = 64'h0;
  logic        m_mis = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [61:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ {2'b00, a[61:32]} ^ 32'h5A5A_0F0F;
  endfunction

  assign Instruction   = mem_word(Inst_Address);
  assign w_instruction = mem_word(w_inst_address);

  instruction_fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC), .Fetch_Valid(Fetch_Valid),
    .Fetch_Ready(Fetch_Ready), .Fetch_Instruction(Fetch_Instruction), .Fetch_PC(Fetch_PC),
    .Buffer_Count(Buffer_Count), .Redirect_Misaligned(Redirect_Misaligned)
  );

  instruction_fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(D)) u_wrap (
    .clk(clk), .reset(reset), .Inst_Address(w_inst_address), .Instruction(w_instruction),
    .Redirect_Valid(1'b0), .Redirect_PC(64'h0), .Fetch_Valid(w_fetch_valid),
    .Fetch_Ready(1'b1), .Fetch_Instruction(w_fetch_instruction), .Fetch_PC(w_fetch_pc),
    .Buffer_Count(w_buffer_count), .Redirect_Misaligned(w_misaligned)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: the buffer is a plain queue of expected {pc, word} in fetch order.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb.delete();
      m_pc  = 64'h0;
      m_mis = 1'b0;
    end else if (Redirect_Valid) begin
      sb.delete();
      m_pc  = {Redirect_PC[63:2], 2'b00};
      m_mis = |Redirect_PC[1:0];
    end else begin
      m_mis = 1'b0;
      if (sb.size() < D) begin
        sb.push_back('{m_pc, mem_word(m_pc[63:2])});
        m_pc = m_pc + 64'd4;
      end
    end
  end

  // Monitor: compare the DUT against the model mid-cycle, consuming on handshake.
  always @(negedge clk) begin
    check("inst_address", 64'(Inst_Address), 64'(m_pc[63:2]));
    check("buffer_count", 64'(Buffer_Count), 64'(sb.size()));
    check("fetch_valid", 64'(Fetch_Valid), 64'(sb.size() != 0));
    check("misaligned", 64'(Redirect_Misaligned), 64'(m_mis));
    if (!reset) begin
      check("reset_fetch_pc", Fetch_PC, 64'h0);
      check("reset_fetch_inst", 64'(Fetch_Instruction), 64'h0);
    end else if (Fetch_Valid && sb.size() != 0) begin
      check("fetch_pc", Fetch_PC, sb[0].pc);
      check("fetch_inst", 64'(Fetch_Instruction), 64'(sb[0].inst));
      if (Fetch_Ready) void'(sb.pop_front());
    end
  end

  initial begin
    cyc(2);
    check("wrap_reset_addr", 64'(w_inst_address), 64'(WRAP_PC[63:2]));
    reset = 1'b1;
    @(negedge clk);
    check("wrap_addr0", 64'(w_inst_address), 64'h3FFF_FFFF_FFFF_FFFF);
    check("wrap_valid0", 64'(w_fetch_valid), 64'h0);
    @(negedge clk);
    check("wrap_addr1", 64'(w_inst_address), 64'h0);
    check("wrap_valid1", 64'(w_fetch_valid), 64'h1);
    check("wrap_pc1", w_fetch_pc, WRAP_PC);
    check("wrap_inst1", 64'(w_fetch_instruction), 64'(mem_word(WRAP_PC[63:2])));
    @(negedge clk);
    check("wrap_pc2", w_fetch_pc, 64'h0);
    cyc(1);

    cyc(8);

    Fetch_Ready = 1'b0;
    cyc(5);
    Fetch_Ready = 1'b1;
    cyc(8);

    Fetch_Ready = 1'b0;
    cyc(3);
    Redirect_Valid = 1'b1;
    Redirect_PC    = 64'h38;
    cyc(1);
    Redirect_Valid = 1'b0;
    cyc(1);
    Fetch_Ready = 1'b1;
    cyc(4);

    Redirect_Valid = 1'b1;
    Redirect_PC    = 64'h0E;
    cyc(1);
    Redirect_PC    = 64'h101;
    cyc(1);
    Redirect_Valid = 1'b0;
    cyc(4);

    for (int i = 0; i < 800; i++) begin
      Fetch_Ready    = ($urandom % 4) != 0;
      Redirect_Valid = ($urandom % 12) == 0;
      if ($urandom % 4 == 0)
        Redirect_PC = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
      else
        Redirect_PC = {$urandom, $urandom};
      cyc(1);
    end

    Redirect_Valid = 1'b0;
    Fetch_Ready    = 1'b0;
    cyc(3);
    check("pre_reset_count", 64'(Buffer_Count), 64'd2);
    reset = 1'b0;
    #1;
    check("async_reset_valid", 64'(Fetch_Valid), 64'h0);
    check("async_reset_addr", 64'(Inst_Address), 64'h0);
    check("async_reset_count", 64'(Buffer_Count), 64'h0);
    cyc(2);
    reset       = 1'b1;
    Fetch_Ready = 1'b1;
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
